// File: rtl/team_06_pkg.sv
// team_06_pkg: shared register map, bit positions and types for the audio tap.
// Register offsets are word indices as decoded from wbs_adr_i[3:2].
package team_06_pkg;

    localparam logic [1:0] TAP_CTRL    = 2'd0;
    localparam logic [1:0] TAP_STATUS  = 2'd1;
    localparam logic [1:0] TAP_DATA    = 2'd2;
    localparam logic [1:0] TAP_OVF_CNT = 2'd3;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_CLEAR_BIT      = 1;

    localparam int STATUS_EMPTY_BIT    = 0;
    localparam int STATUS_FULL_BIT     = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;
    localparam int STATUS_COUNT_LSB    = 8;

    localparam int DATA_VALID_BIT      = 31;

    typedef logic [7:0] tap_sample_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;

    // DATA register image: valid flag in bit 31 and the sample in [7:0],
    // or all zeroes when there is nothing to return.
    function automatic logic [31:0] pack_data(input logic valid, input tap_sample_t s);
        logic [31:0] v;
        v = '0;
        if (valid) begin
            v[DATA_VALID_BIT] = 1'b1;
            v[7:0]            = s;
        end
        return v;
    endfunction

endpackage

// File: rtl/team_06_sample_fifo.sv
// team_06_sample_fifo: circular sample FIFO with occupancy counter.
// A push into a full FIFO is only taken when a pop happens in the same cycle,
// so stored samples are never overwritten. Clear beats push and pop.
module team_06_sample_fifo
    import team_06_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
)
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  tap_sample_t       din,
    output tap_sample_t       dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    tap_sample_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping, wrapping naturally modulo DEPTH.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/team_06_wb_audio_tap.sv
// team_06_wb_audio_tap: Wishbone classic responder that buffers processed
// audio samples for the management CPU. Each DATA read pops one sample.
// Optional feature macro: TEAM_06_TAP_OVF_CNT_EN adds a saturating 16-bit
// dropped-sample counter at offset 0xC; without it that offset reads zero.
module team_06_wb_audio_tap
    import team_06_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
)
(
    input  logic         CLK,
    input  logic         nRST,
    input  logic [7:0]   sample_i,
    input  logic         sample_valid_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic         irq_o
);

    wb_state_t          r_state;
    wb_state_t          w_next_state;
    logic               w_req;

    logic               r_enable;
    logic               r_overflow;
    logic               r_irq;
    logic [31:0]        r_dat;
`ifdef TEAM_06_TAP_OVF_CNT_EN
    logic [15:0]        r_ovf_cnt;
`endif

    logic [1:0]         w_off;
    logic               w_rd;
    logic               w_wr;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_clear;
    logic               w_ovf_w1c;
    logic [31:0]        w_rdata;

    tap_sample_t        w_dout;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_unused;

    // Address bits above [3:2] are decoded by the interconnect, and only the
    // low byte lane carries writable bits.
    assign w_unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:3]};

    assign w_off     = wbs_adr_i[3:2];
    assign w_rd      = w_req & ~wbs_we_i;
    assign w_wr      = w_req & wbs_we_i & wbs_sel_i[0];
    assign w_pop     = w_rd & (w_off == TAP_DATA) & ~w_empty;
    assign w_clear   = w_wr & (w_off == TAP_CTRL) & wbs_dat_i[CTRL_CLEAR_BIT];
    assign w_ovf_w1c = w_wr & (w_off == TAP_STATUS) & wbs_dat_i[STATUS_OVERFLOW_BIT];
    assign w_push    = sample_valid_i & r_enable;
    assign w_drop    = w_push & w_full & ~w_pop;

    assign wbs_ack_o = (r_state == WB_ACK);
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;

    team_06_sample_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (w_push),
        .pop   (w_pop),
        .clear (w_clear),
        .din   (sample_i),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Bus handshake state register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A request is accepted only from IDLE, so a held strobe gets one ack every other cycle.
    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    w_req        = 1'b1;
                    w_next_state = WB_ACK;
                end
            end
            WB_ACK: begin
                w_next_state = WB_IDLE;
            end
        endcase
    end

    // Read data mux built from the state as it stands before the access edge.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            TAP_CTRL: begin
                w_rdata[CTRL_ENABLE_BIT] = r_enable;
            end
            TAP_STATUS: begin
                w_rdata[STATUS_EMPTY_BIT]           = w_empty;
                w_rdata[STATUS_FULL_BIT]            = w_full;
                w_rdata[STATUS_OVERFLOW_BIT]        = r_overflow;
                w_rdata[STATUS_COUNT_LSB +: 8]      = 8'(w_count);
            end
            TAP_DATA: begin
                w_rdata = pack_data(~w_empty, w_dout);
            end
            TAP_OVF_CNT: begin
`ifdef TEAM_06_TAP_OVF_CNT_EN
                w_rdata[15:0] = r_ovf_cnt;
`else
                w_rdata = '0;
`endif
            end
        endcase
    end

    // Read data is only non-zero during the ack cycle of a read.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_dat <= '0;
        end else if (w_rd) begin
            r_dat <= w_rdata;
        end else begin
            r_dat <= '0;
        end
    end

    // CTRL enable and the sticky overflow flag; a drop in the same cycle as a
    // write-1-to-clear keeps the flag set so no drop goes unreported.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr && (w_off == TAP_CTRL)) begin
                r_enable <= wbs_dat_i[CTRL_ENABLE_BIT];
            end
            if (w_clear) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_w1c) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Interrupt follows enable and non-empty with one cycle of latency.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_enable & ~w_empty;
        end
    end

`ifdef TEAM_06_TAP_OVF_CNT_EN
    // Dropped-sample counter, saturating so it never wraps back to a small value.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ovf_cnt <= '0;
        end else if (w_clear) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_team_06_wb_audio_tap.sv
// tb_team_06_wb_audio_tap: directed and randomized bench for the audio tap,
// checked against a queue-based model of the register map and FIFO.
module tb_team_06_wb_audio_tap;

    localparam int DEPTH = 16;

    logic         CLK = 1'b0;
    logic         nRST;
    logic [7:0]   sample_i;
    logic         sample_valid_i;
    logic         wbs_stb_i;
    logic         wbs_cyc_i;
    logic         wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i;
    logic [31:0]  wbs_dat_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic         irq_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]   modelQ[$];
    bit           modelEnable;
    bit           modelOvf;
    int           modelOvfCnt;

    team_06_wb_audio_tap #(.DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .wbs_stb_i      (wbs_stb_i),
        .wbs_cyc_i      (wbs_cyc_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_sel_i      (wbs_sel_i),
        .wbs_adr_i      (wbs_adr_i),
        .wbs_dat_i      (wbs_dat_i),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .irq_o          (irq_o)
    );

    always #5 CLK = ~CLK;

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expStatus();
        logic [31:0] v;
        v = '0;
        v[0]    = (modelQ.size() == 0);
        v[1]    = (modelQ.size() == DEPTH);
        v[2]    = modelOvf;
        v[15:8] = 8'(modelQ.size());
        return v;
    endfunction

    function automatic logic [31:0] expOvfCnt();
`ifdef TEAM_06_TAP_OVF_CNT_EN
        return {16'h0, 16'(modelOvfCnt)};
`else
        return 32'h0;
`endif
    endfunction

    function automatic void modelPush(input logic [7:0] b);
        if (!modelEnable) return;
        if (modelQ.size() < DEPTH) begin
            modelQ.push_back(b);
        end else begin
            modelOvf = 1'b1;
            if (modelOvfCnt < 65535) modelOvfCnt++;
        end
    endfunction

    function automatic logic [31:0] modelRead(input logic [1:0] word);
        logic [31:0] v;
        v = '0;
        case (word)
            2'd0: v = {31'b0, modelEnable};
            2'd1: v = expStatus();
            2'd2: if (modelQ.size() > 0) v = {1'b1, 23'b0, modelQ.pop_front()};
            2'd3: v = expOvfCnt();
        endcase
        return v;
    endfunction

    function automatic void modelWrite(input logic [1:0] word, input logic [31:0] data, input logic [3:0] sel);
        if (!sel[0]) return;
        if (word == 2'd0) begin
            modelEnable = data[0];
            if (data[1]) begin
                modelQ.delete();
                modelOvf    = 1'b0;
                modelOvfCnt = 0;
            end
        end else if (word == 2'd1) begin
            if (data[2]) modelOvf = 1'b0;
        end
    endfunction

    // Push one sample through the strobe interface.
    task automatic applyStimulus(input logic [7:0] b);
        sample_i       = b;
        sample_valid_i = 1'b1;
        @(posedge CLK); #1;
        sample_valid_i = 1'b0;
        modelPush(b);
    endtask

    // Wait for the single ack of a request, then release the bus for a cycle.
    task automatic waitAck(input string tag, output logic [31:0] observed);
        int lat;
        lat      = 0;
        observed = 32'hDEAD_BEEF;
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK); #1;
            sample_valid_i = 1'b0;
            if (wbs_ack_o) begin
                lat      = i;
                observed = wbs_dat_o;
                break;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        checkOutput({tag, "_lat"}, 32'(lat), 32'd1);
        @(posedge CLK); #1;
        checkOutput({tag, "_ackrel"}, {31'b0, wbs_ack_o}, 32'd0);
    endtask

    task automatic wbRead(input string tag, input logic [1:0] word, input bit withPush, input logic [7:0] pushByte);
        logic [31:0] expected;
        logic [31:0] observed;
        wbs_adr_i = ($urandom() & 32'hFFFF_FFF0) | {28'h0, word, 2'b00};
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        if (withPush) begin
            sample_i       = pushByte;
            sample_valid_i = 1'b1;
        end
        expected = modelRead(word);
        if (withPush) modelPush(pushByte);
        waitAck(tag, observed);
        checkOutput(tag, observed, expected);
        checkOutput({tag, "_datrel"}, wbs_dat_o, 32'd0);
    endtask

    task automatic wbWrite(input string tag, input logic [1:0] word, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] observed;
        wbs_adr_i = ($urandom() & 32'hFFFF_FFF0) | {28'h0, word, 2'b00};
        wbs_dat_i = data;
        wbs_we_i  = 1'b1;
        wbs_sel_i = sel;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        waitAck(tag, observed);
        modelWrite(word, data, sel);
    endtask

    task automatic irqCheck(input string tag);
        @(posedge CLK); #1;
        checkOutput(tag, {31'b0, irq_o}, {31'b0, (modelEnable && modelQ.size() > 0)});
    endtask

    initial begin
        int acks;
        int op;
        nRST           = 1'b0;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        wbs_stb_i      = 1'b0;
        wbs_cyc_i      = 1'b0;
        wbs_we_i       = 1'b0;
        wbs_sel_i      = 4'h0;
        wbs_adr_i      = '0;
        wbs_dat_i      = '0;
        modelEnable    = 1'b0;
        modelOvf       = 1'b0;
        modelOvfCnt    = 0;

        // Reset and idle
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        checkOutput("rst_dat", wbs_dat_o, 32'd0);
        checkOutput("rst_irq", {31'b0, irq_o}, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;
        wbRead("rst_status", 2'd1, 1'b0, 8'h0);
        wbRead("rst_ovfcnt", 2'd3, 1'b0, 8'h0);

        // Ordered readback
        wbWrite("ctrl_en", 2'd0, 32'h1, 4'hF);
        applyStimulus(8'h40);
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        irqCheck("irq_on");
        wbRead("order_0", 2'd2, 1'b0, 8'h0);
        wbRead("order_1", 2'd2, 1'b0, 8'h0);
        wbRead("order_2", 2'd2, 1'b0, 8'h0);
        wbRead("order_empty", 2'd2, 1'b0, 8'h0);
        irqCheck("irq_off");

        // Empty read coinciding with a push: read is empty, push lands
        wbRead("empty_pushpop", 2'd2, 1'b1, 8'h5A);
        wbRead("empty_pushpop_st", 2'd1, 1'b0, 8'h0);
        wbRead("empty_pushpop_rd", 2'd2, 1'b0, 8'h0);

        // Overflow: 20 pushes into 16 entries
        for (int i = 0; i < 20; i++) applyStimulus(8'($urandom()));
        wbRead("ovf_status", 2'd1, 1'b0, 8'h0);
        wbRead("ovf_cnt", 2'd3, 1'b0, 8'h0);

        // Simultaneous push and pop while full
        wbRead("full_pushpop", 2'd2, 1'b1, 8'hA5);
        wbRead("full_pushpop_st", 2'd1, 1'b0, 8'h0);
        wbRead("full_pushpop_cnt", 2'd3, 1'b0, 8'h0);

        // Overflow write-1-to-clear, byte select and DATA write behaviour
        wbWrite("w1c_nosel", 2'd1, 32'h4, 4'hE);
        wbRead("w1c_nosel_st", 2'd1, 1'b0, 8'h0);
        wbWrite("w1c", 2'd1, 32'h4, 4'hF);
        wbRead("w1c_st", 2'd1, 1'b0, 8'h0);
        wbWrite("data_wr", 2'd2, 32'hFFFF_FFFF, 4'hF);
        wbRead("data_wr_st", 2'd1, 1'b0, 8'h0);
        wbRead("w1c_cnt", 2'd3, 1'b0, 8'h0);
        for (int i = 0; i < DEPTH; i++) wbRead("drain", 2'd2, 1'b0, 8'h0);
        wbRead("drain_empty", 2'd2, 1'b0, 8'h0);

        // Clear and disable
        for (int i = 0; i < 18; i++) applyStimulus(8'($urandom()));
        wbWrite("ctrl_clear", 2'd0, 32'h3, 4'hF);
        wbRead("clear_st", 2'd1, 1'b0, 8'h0);
        wbRead("clear_cnt", 2'd3, 1'b0, 8'h0);
        wbRead("clear_ctrl", 2'd0, 1'b0, 8'h0);
        wbWrite("ctrl_dis", 2'd0, 32'h0, 4'hF);
        applyStimulus(8'h77);
        wbRead("dis_st", 2'd1, 1'b0, 8'h0);
        irqCheck("dis_irq");

        // Held strobe on DATA with two entries
        wbWrite("held_en", 2'd0, 32'h1, 4'hF);
        applyStimulus(8'($urandom()));
        applyStimulus(8'($urandom()));
        wbs_adr_i = 32'h0000_0008;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            if (wbs_ack_o) begin
                acks++;
                checkOutput("held_data", wbs_dat_o, modelRead(2'd2));
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        checkOutput("held_acks", 32'(acks), 32'd2);
        wbRead("held_st", 2'd1, 1'b0, 8'h0);

        // Randomized mix of pushes, reads and control writes
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: applyStimulus(8'($urandom()));
                4, 5:       wbRead("rnd_data", 2'd2, 1'($urandom_range(0, 1)), 8'($urandom()));
                6:          wbRead("rnd_status", 2'd1, 1'($urandom_range(0, 1)), 8'($urandom()));
                7:          wbRead("rnd_ovf", 2'd3, 1'($urandom_range(0, 1)), 8'($urandom()));
                8:          wbWrite("rnd_ctrl", 2'd0,
                                    {30'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0)},
                                    4'hF);
                default:    irqCheck("rnd_irq");
            endcase
        end
        wbRead("rnd_final_st", 2'd1, 1'b0, 8'h0);
        wbRead("rnd_final_ctrl", 2'd0, 1'b0, 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/team_06_wb_audio_tap.md
# team_06_wb_audio_tap

Wishbone classic responder that buffers processed audio samples so the management CPU can pull them. One side is a sample strobe interface, fed from the effect output path (8-bit `audio_out` with a one-cycle valid). The other side is a 4-register Wishbone slave that sits on the same interconnect as the SRAM wrapper. It is the responder-side counterpart to the team's Wishbone manager: it receives `STB/CYC` and returns `ACK/DAT`. Samples go into a circular FIFO, and each read of the DATA register pops one sample.

## Interface
Parameters:
- `DEPTH`, 16: number of FIFO entries; must be a power of 2 and at least 2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of the occupancy counter.

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `nRST`  in  1  reset; synchronous, active-low.
- `sample_i`  in  8  processed audio sample.
- `sample_valid_i`  in  1  one-cycle strobe that qualifies `sample_i`.
- `wbs_stb_i`  in  1  Wishbone strobe.
- `wbs_cyc_i`  in  1  Wishbone cycle.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte selects; only bit 0 is honoured for writes.
- `wbs_adr_i`  in  32  address; only bits [3:2] are decoded, higher bits are decoded by the interconnect.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data.
- `irq_o`  out  1  high while the tap is enabled and the FIFO is non-empty.

## Operation
Register map, by word offset:
- 0x0 CTRL (RW)
  - bit0 `enable`.
  - bit1 `clear`: write-1, self-clearing, reads 0.
- 0x4 STATUS
  - bit0 `empty` (RO).
  - bit1 `full` (RO).
  - bit2 `overflow`: sticky; write-1-to-clear.
  - [15:8] `count` (RO), zero-extended.
- 0x8 DATA (RO)
  - [7:0] head sample; bit31 `valid`.
  - A read while non-empty returns valid=1 and pops one entry.
  - A read while empty returns 0x0000_0000 and does not pop.
  - Writes are acknowledged and ignored.
- 0xC OVF_CNT (RO): number of dropped samples; see Configuration.

Push rules:
- A sample is pushed when `sample_valid_i` and `enable` are both high.
- If the FIFO is full and no pop occurs in that cycle, the new sample is dropped and `overflow` is set. Existing samples are never overwritten.
- If the FIFO is full and a pop occurs in the same cycle, the push is accepted and `count` is unchanged.
- If the FIFO is empty and a DATA read coincides with a push, the read returns empty and the push is accepted.
- Clear has priority over push and pop. It sets `count`=0, resets both pointers, clears `overflow`, and zeroes OVF_CNT.

Other rules:
- Pointers wrap modulo `DEPTH`; `count` ranges from 0 to `DEPTH`.
- Writes with `wbs_sel_i[0]`=0 change nothing but are still acknowledged.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0, `enable`=0, `count`=0, pointers=0, `overflow`=0, OVF_CNT=0.
- Access latency is one wait state. A request is `stb & cyc & ~ack` sampled at edge N. At edge N+1:
  - `wbs_ack_o` rises for exactly one cycle;
  - `wbs_dat_o` is registered in the same edge;
  - side effects take place: pop, CTRL/STATUS update, clear.
- `ack` stays low in the cycle after an ack even if `stb` is still held, so one request produces exactly one ack and one pop.
- Back-to-back requests are therefore acknowledged every other cycle.
- `wbs_dat_o` returns to 0 when `ack` is low.
- A sample pushed at edge N is visible in `count` and readable at edge N+1.
- `irq_o` is registered and follows `enable & ~empty` with one cycle of latency.
- Reset asserted mid-transaction: `ack` is not issued, and all state returns to its reset value on the next edge.

## Configuration
- `TEAM_06_TAP_OVF_CNT_EN` defined:
  - OVF_CNT is a 16-bit counter, saturating at 0xFFFF, incremented once per dropped sample.
  - It is cleared by reset or `clear`.
- Macro undefined:
  - the counter logic is absent;
  - offset 0xC reads 0x0000_0000;
  - the sticky `overflow` bit behaves identically in both builds.

## Structure
- `team_06_pkg` holds:
  - register offsets `TAP_CTRL`, `TAP_STATUS`, `TAP_DATA`, `TAP_OVF_CNT`;
  - CTRL/STATUS bit positions;
  - typedef `tap_sample_t` (logic [7:0]).
- Sub-module `team_06_sample_fifo`:
  - parameterised by `DEPTH`;
  - inputs `push`, `pop`, `clear`, `din`;
  - outputs `dout`, `count`, `full`, `empty`.
- The top level contains the Wishbone FSM (IDLE → ACK → IDLE), the register decode, and the overflow logic.

## Test plan
- **Reset and idle:** drive `nRST`=0 for 3 cycles → every output is 0; a STATUS read then returns 0x0000_0001.
- **Ordered readback:** write CTRL=1, push 0x40, 0x41, 0x42, then read DATA three times → 0x8000_0040, 0x8000_0041, 0x8000_0042; a fourth read returns 0. Each ack arrives exactly one cycle after `stb`.
- **Overflow:** with DEPTH=16, push 20 samples → STATUS=0x0000_1006, OVF_CNT=4 (0 in the macro-off build), and readback yields the first 16 samples.
- **Simultaneous push and pop when full:** DATA read and push in the same cycle → `count` stays 16, `overflow` unchanged, the popped sample is the oldest.
- **Clear and disable:** write CTRL=0x3 → STATUS=0x0000_0001 on the next read; with CTRL=0, a push is ignored and `irq_o` stays 0.
- **Held strobe:** hold `stb`/`cyc` for 4 cycles on DATA with 2 entries → exactly 2 acks, 2 pops, in order.
